memory: RTL and testbench
=========================

// Module: memory
// PURPOSE
//  Byte-addressed, word-accessed main memory for the MIPS processor model.
//  Holds program image and data, mapped at a fixed base address.
//  Serves single-word and fixed-length burst reads/writes on one port.
//  Reads are combinational; writes commit on the rising clock edge.
// PARAMETERS
//  DATA_WIDTH     32            word width in bits
//  ADDRESS_WIDTH  32            byte-address width
//  DEPTH          1048576       storage size in bytes (must be a multiple of 4)
//  START_ADDR     32'h80020000  byte address of storage byte 0
// PORTS
//  clock        in   1   sole clock; all state updates on its rising edge
//  reset        in   1   asynchronous, active-high; clears control state only
//  address      in   32  byte address; bits [1:0] ignored (word-aligned access)
//  data_in      in   32  write data
//  access_size  in   2   00=1 word, 01=4-word burst, 10=8-word, 11=16-word
//  rw           in   1   0=write, 1=read
//  enable       in   1   request valid
//  busy         out  1   burst in progress; new requests are ignored while high
//  data_out     out  32  read data
// BEHAVIOUR
//  - Mapping: offset = address - START_ADDR, then bits [1:0] forced to 0.
//  - In range when offset < DEPTH (unsigned compare).
//  - Big-endian byte order: word bits [31:24] sit at offset, [7:0] at offset+3.
//  - Out-of-range beat: writes are dropped; reads return 32'h0.
//  - Effective address: address input when busy=0; base+4*beat when busy=1.
//  - data_out = mem[eff addr] combinationally when enable=1 and rw=1 (idle),
//    or when a read burst is active. Otherwise data_out = 0.
//  - Single word (access_size=00), busy=0, enable=1:
//    - at posedge with rw=0: write data_in to mem[address];
//    - read is valid before the posedge and stays valid while address is held;
//    - busy stays 0.
//  - Burst start (access_size!=00, busy=0, enable=1 at posedge):
//    - beat 0 is performed on address (written if rw=0);
//    - latch base=address, rw and length N (4/8/16); set beat=1, busy=1.
//  - Burst beats k=1..N-1 (one per posedge, address at base+4k):
//    - write beats take data_in at each posedge;
//    - read beats present mem[base+4k] on data_out during beat k;
//    - enable, rw, address and access_size are ignored; no abort except reset;
//    - busy falls at the posedge that completes beat N-1.
//  - Bursts never wrap; a beat past the top of storage follows the
//    out-of-range rule.
//  - enable=0 while idle: no state change, data_out=0.
//  - Reset (asynchronous, mid-burst included):
//    - busy=0, beat=0, latched burst state cleared;
//    - data_out=0 until the next read request;
//    - storage contents are NOT cleared (initial contents undefined).
// TESTING
//  - Single-word write sweep:
//    - write 0x8FBF0010, 0x27BDFFE8, 0x00000000 to 0x80020000/04/08;
//    - read each back -> identical words, busy stays 0.
//  - Byte order: write 0x11223344 at 0x80020010;
//    - reading 0x80020013 (bits [1:0] ignored) -> 0x11223344;
//    - internal byte at offset 0x10 == 0x11.
//  - 4-word write burst at 0x80020100 with data 1,2,3,4:
//    - busy high for 3 cycles after the start edge;
//    - a read burst of the same 4 words returns 1,2,3,4 on consecutive cycles.
//  - Out of range:
//    - write to 0x80120000 and to 0x8001FFFC -> no effect;
//    - reads at those addresses -> 0x00000000.
//  - Reset mid 16-word burst (after beat 5):
//    - busy drops at once; beats 0-5 keep their data;
//    - the next request starts a fresh burst.
//  - enable=0 with rw=1 -> data_out=0; a write attempted with enable=0
//    leaves memory unchanged.

Source files
------------

// File: rtl/memory.sv
// rtl/memory.sv - byte-addressed, word-accessed main memory with fixed-length bursts
module memory #(
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DEPTH         = 1048576,
    parameter logic [ADDRESS_WIDTH-1:0]   START_ADDR    = 'h80020000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [1:0]               access_size,
    input  logic                     rw,
    input  logic                     enable,
    output logic                     busy,
    output logic [DATA_WIDTH-1:0]    data_out
);

    localparam int                       IDX_W   = $clog2(DEPTH);
    localparam int                       BYTES   = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(DEPTH);

    logic [7:0] mem [DEPTH];

    logic [ADDRESS_WIDTH-1:0] base;
    logic                     burst_rw;
    logic [3:0]               beat;
    logic [3:0]               last_beat;

    logic [ADDRESS_WIDTH-1:0] eff_addr;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [IDX_W-1:0]         idx;
    logic                     in_range;
    logic                     read_active;
    logic                     write_active;
    logic [DATA_WIDTH-1:0]    read_word;

    function automatic logic [3:0] burst_last(input logic [1:0] size);
        case (size)
            2'b01:   burst_last = 4'd3;
            2'b10:   burst_last = 4'd7;
            default: burst_last = 4'd15;
        endcase
    endfunction

    // While a burst runs the port inputs are ignored; the latched base drives the beat address.
    assign eff_addr     = busy ? base + ADDRESS_WIDTH'({beat, 2'b00}) : address;
    assign offset       = eff_addr - START_ADDR;
    assign in_range     = offset < DEPTH_A;
    assign idx          = {offset[IDX_W-1:2], 2'b00};
    assign read_active  = busy ? burst_rw  : (enable && rw);
    assign write_active = busy ? !burst_rw : (enable && !rw);

    // Big-endian: the most significant byte lives at the lowest offset.
    always_comb begin
        read_word = '0;
        for (int b = 0; b < BYTES; b++) begin
            read_word[DATA_WIDTH-1-8*b -: 8] = mem[idx + IDX_W'(b)];
        end
    end

    assign data_out = (read_active && in_range) ? read_word : '0;

    // Storage has no reset; out-of-range writes must not alias onto wrapped indices.
    always_ff @(posedge clock) begin
        if (!reset && write_active && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                mem[idx + IDX_W'(b)] <= data_in[DATA_WIDTH-1-8*b -: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            beat      <= 4'd0;
            base      <= '0;
            burst_rw  <= 1'b0;
            last_beat <= 4'd0;
        end else if (busy) begin
            if (beat == last_beat) begin
                busy <= 1'b0;
                beat <= 4'd0;
            end else begin
                beat <= beat + 4'd1;
            end
        end else if (enable && access_size != 2'b00) begin
            busy      <= 1'b1;
            beat      <= 4'd1;
            base      <= address;
            burst_rw  <= rw;
            last_beat <= burst_last(access_size);
        end
    end

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed self-checking bench for memory
module tb_memory;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        busy;
    logic [31:0] data_out;

    int total = 0;
    int bad   = 0;

    memory dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data_in     (data_in),
        .access_size (access_size),
        .rw          (rw),
        .enable      (enable),
        .busy        (busy),
        .data_out    (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; sampling happens 2ns later, well before the rising edge.
    task automatic drive(input logic en, input logic r, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        enable      = en;
        rw          = r;
        access_size = sz;
        address     = a;
        data_in     = d;
        #2;
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        enable      = 1'b1;
        rw          = 1'b1;
        access_size = 2'b00;
        address     = 32'h80020000;
        data_in     = 32'h0;
        #2;
        chk("reset_busy", {31'b0, busy}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        enable = 1'b0;
        #1;
        chk("reset_data_out", data_out, 32'h0);
        reset = 1'b0;

        drive(1, 0, 2'b00, 32'h80020000, 32'h8FBF0010);
        drive(1, 0, 2'b00, 32'h80020004, 32'h27BDFFE8);
        drive(1, 0, 2'b00, 32'h80020008, 32'h00000000);
        drive(1, 1, 2'b00, 32'h80020000, 32'h0);
        chk("sweep_rd0", data_out, 32'h8FBF0010);
        chk("sweep_busy", {31'b0, busy}, 32'h0);
        drive(1, 1, 2'b00, 32'h80020004, 32'h0);
        chk("sweep_rd1", data_out, 32'h27BDFFE8);
        drive(1, 1, 2'b00, 32'h80020008, 32'h0);
        chk("sweep_rd2", data_out, 32'h00000000);
        chk("sweep_busy2", {31'b0, busy}, 32'h0);

        drive(1, 0, 2'b00, 32'h80020010, 32'h11223344);
        drive(1, 1, 2'b00, 32'h80020013, 32'h0);
        chk("byte_order_rd", data_out, 32'h11223344);
        chk("byte_order_msb", {24'h0, dut.mem[16]}, 32'h11);
        chk("byte_order_lsb", {24'h0, dut.mem[19]}, 32'h44);

        drive(1, 0, 2'b01, 32'h80020100, 32'd1);
        chk("bw_busy0", {31'b0, busy}, 32'h0);
        drive(0, 1, 2'b00, 32'h00000000, 32'd2);
        chk("bw_busy1", {31'b0, busy}, 32'h1);
        chk("bw_no_read", data_out, 32'h0);
        drive(0, 1, 2'b10, 32'h00000000, 32'd3);
        chk("bw_busy2", {31'b0, busy}, 32'h1);
        drive(1, 1, 2'b11, 32'h00000000, 32'd4);
        chk("bw_busy3", {31'b0, busy}, 32'h1);
        drive(0, 0, 2'b00, 32'h00000000, 32'h0);
        chk("bw_busy_end", {31'b0, busy}, 32'h0);

        drive(1, 1, 2'b01, 32'h80020100, 32'h0);
        chk("br_beat0", data_out, 32'd1);
        drive(0, 0, 2'b00, 32'h00000000, 32'h0);
        chk("br_busy1", {31'b0, busy}, 32'h1);
        chk("br_beat1", data_out, 32'd2);
        drive(0, 0, 2'b00, 32'h00000000, 32'h0);
        chk("br_beat2", data_out, 32'd3);
        drive(0, 0, 2'b00, 32'h00000000, 32'h0);
        chk("br_beat3", data_out, 32'd4);
        drive(0, 0, 2'b00, 32'h00000000, 32'h0);
        chk("br_busy_end", {31'b0, busy}, 32'h0);
        chk("br_idle_out", data_out, 32'h0);

        drive(1, 0, 2'b00, 32'h8011FFFC, 32'h55AA55AA);
        drive(1, 0, 2'b00, 32'h80120000, 32'hDEADBEEF);
        drive(1, 0, 2'b00, 32'h8001FFFC, 32'hCAFEF00D);
        drive(1, 1, 2'b00, 32'h80120000, 32'h0);
        chk("oor_rd_high", data_out, 32'h0);
        drive(1, 1, 2'b00, 32'h8001FFFC, 32'h0);
        chk("oor_rd_low", data_out, 32'h0);
        drive(1, 1, 2'b00, 32'h80020000, 32'h0);
        chk("oor_no_alias_low", data_out, 32'h8FBF0010);
        drive(1, 1, 2'b00, 32'h8011FFFC, 32'h0);
        chk("oor_top_word", data_out, 32'h55AA55AA);

        drive(1, 0, 2'b00, 32'h80020218, 32'h66666666);
        drive(1, 0, 2'b11, 32'h80020200, 32'hA0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 2'b00, 32'h0, 32'hA0 + k);
        end
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("rst_busy_drop", {31'b0, busy}, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            drive(1, 1, 2'b00, 32'h80020200 + 4 * k, 32'h0);
            chk($sformatf("rst_kept_beat%0d", k), data_out, 32'hA0 + k);
        end
        drive(1, 1, 2'b00, 32'h80020218, 32'h0);
        chk("rst_beat6_untouched", data_out, 32'h66666666);

        drive(1, 1, 2'b01, 32'h80020200, 32'h0);
        chk("fresh_beat0", data_out, 32'hA0);
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        chk("fresh_busy", {31'b0, busy}, 32'h1);
        chk("fresh_beat1", data_out, 32'hA1);
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        chk("fresh_beat2", data_out, 32'hA2);
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        chk("fresh_beat3", data_out, 32'hA3);
        drive(0, 0, 2'b00, 32'h0, 32'h0);
        chk("fresh_done", {31'b0, busy}, 32'h0);

        drive(1, 1, 2'b10, 32'h80020000, 32'h0);
        chk("b8_beat0", data_out, 32'h8FBF0010);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 2'b00, 32'h0, 32'h0);
            if (busy) n++;
            else break;
        end
        chk("b8_busy_cycles", n, 32'd7);

        drive(0, 1, 2'b00, 32'h80020000, 32'h0);
        chk("dis_read_zero", data_out, 32'h0);
        drive(0, 0, 2'b00, 32'h80020000, 32'hFFFFFFFF);
        drive(1, 1, 2'b00, 32'h80020000, 32'h0);
        chk("dis_write_ignored", data_out, 32'h8FBF0010);
        chk("dis_busy", {31'b0, busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
